// File: rtl/byte_joiner.sv
`default_nettype none
// ============================================================================
//  Module      : byte_joiner
//  Description : Packs a byte stream into 32-bit words, first byte in [31:24].
//                A level flush request emits a partial word, zero-padded in
//                the low bytes, with out_cnt giving the number of valid bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_joiner (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    input  logic        in_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [2:0]  out_cnt
);

    localparam logic [1:0] LAST_SLOT = 2'd3;

    logic [31:0] acc_q,      acc_d;
    logic [1:0]  cnt_q,      cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_word_q, out_word_d;
    logic [2:0]  out_cnt_q,  out_cnt_d;

    logic        slot_free;
    logic        accept;
    logic [2:0]  eff_cnt;
    logic [31:0] acc_ins;
    logic        word_full;
    logic        flush_ok;

    // Handshake decode: the last free byte slot may only fill when the
    // finished word has somewhere to go in the same cycle.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        in_ready  = (cnt_q != LAST_SLOT) || slot_free;
        accept    = in_valid && in_ready;
        eff_cnt   = {1'b0, cnt_q} + {2'b00, accept};
        word_full = accept && (cnt_q == LAST_SLOT);
        // A full word already satisfies a coincident flush.
        flush_ok  = in_flush && slot_free && (eff_cnt != 3'd0) && !word_full;
    end

    // Accumulator image including the byte accepted this cycle, if any.
    always_comb begin
        acc_ins = acc_q;
        if (accept) begin
            case (cnt_q)
                2'd0:    acc_ins[31:24] = in_byte;
                2'd1:    acc_ins[23:16] = in_byte;
                2'd2:    acc_ins[15:8]  = in_byte;
                default: acc_ins[7:0]   = in_byte;
            endcase
        end
    end

    // Next-state: either hand the accumulated bytes to the output slot and
    // restart empty, or keep collecting while the slot drains independently.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_word_d  = out_word_q;
        out_cnt_d   = out_cnt_q;
        if (word_full || flush_ok) begin
            out_word_d  = acc_ins;
            out_cnt_d   = eff_cnt;
            out_valid_d = 1'b1;
            acc_d       = 32'h0;
            cnt_d       = 2'd0;
        end else if (accept) begin
            acc_d = acc_ins;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q       <= 32'h0;
            cnt_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0;
            out_cnt_q   <= 3'd0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_cnt   = out_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_joiner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_joiner
//  Description : Self-checking bench for byte_joiner: directed scenarios with
//                literal expectations, then randomized traffic compared every
//                cycle against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_joiner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        in_flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [2:0]  out_cnt;

    int total = 0;
    int bad   = 0;

    byte_joiner dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted bytes kept in a queue; a word leaves when the
    // queue reaches four bytes or an effective flush arrives.
    logic [7:0]  pend[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_word  = 32'h0;
    logic [2:0]  m_cnt   = 3'd0;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        bit          free;
        bit          rdy;
        logic [31:0] w;
        if (!reset) begin
            pend.delete();
            m_valid  = 1'b0;
            m_word   = 32'h0;
            m_cnt    = 3'd0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            free = !m_valid || out_ready;
            rdy  = (pend.size() < 3) || free;
            if (in_valid && rdy) pend.push_back(in_byte);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (pend.size() == 4 || (in_flush && free && pend.size() > 0)) begin
                w = 32'h0;
                for (int i = 0; i < pend.size(); i++)
                    w = w | (32'(pend[i]) << (24 - 8 * i));
                m_word  = w;
                m_cnt   = 3'(pend.size());
                m_valid = 1'b1;
                pend.delete();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok && reset) begin
            chk("in_ready", {31'b0, in_ready},
                {31'b0, (pend.size() < 3) || !m_valid || out_ready});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("out_word", out_word, m_word);
                chk("out_cnt", {29'b0, out_cnt}, {29'b0, m_cnt});
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] b, input logic f, input logic r);
        in_valid  = v;
        in_byte   = b;
        in_flush  = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_word", out_word, 32'h0);
        chk("rst_cnt", {29'b0, out_cnt}, 32'h0);
        reset = 1'b1;
        step(0, 8'h00, 0, 1);
        chk("rst_ready", {31'b0, in_ready}, 32'h1);

        // Four bytes back to back make one full word
        step(1, 8'hAB, 0, 1);
        step(1, 8'hCD, 0, 1);
        step(1, 8'h12, 0, 1);
        step(1, 8'h34, 0, 1);
        chk("full_valid", {31'b0, out_valid}, 32'h1);
        chk("full_word", out_word, 32'hABCD1234);
        chk("full_cnt", {29'b0, out_cnt}, 32'd4);
        step(0, 8'h00, 0, 1);
        chk("full_drain", {31'b0, out_valid}, 32'h0);

        // Partial flush, then next word restarts at the top byte
        step(1, 8'h04, 0, 1);
        step(1, 8'hA5, 0, 1);
        step(0, 8'h00, 1, 1);
        chk("flush2_word", out_word, 32'h04A50000);
        chk("flush2_cnt", {29'b0, out_cnt}, 32'd2);
        step(1, 8'h77, 0, 1);
        step(0, 8'h00, 1, 1);
        chk("flush1_word", out_word, 32'h77000000);
        chk("flush1_cnt", {29'b0, out_cnt}, 32'd1);
        step(0, 8'h00, 0, 1);

        // Stalled output: in_ready drops at cnt==3, 4th byte taken on release
        step(1, 8'h45, 0, 0);
        step(1, 8'h14, 0, 0);
        step(0, 8'h00, 1, 0);
        chk("stall_word", out_word, 32'h45140000);
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        chk("stall_ready", {31'b0, in_ready}, 32'h0);
        step(1, 8'h04, 0, 0);
        chk("stall_hold_word", out_word, 32'h45140000);
        chk("stall_hold_cnt", {29'b0, out_cnt}, 32'd2);
        chk("stall_hold_valid", {31'b0, out_valid}, 32'h1);
        step(1, 8'h04, 0, 1);
        chk("release_valid", {31'b0, out_valid}, 32'h1);
        chk("release_word", out_word, 32'h01020304);
        chk("release_cnt", {29'b0, out_cnt}, 32'd4);
        step(0, 8'h00, 0, 1);

        // Flush held while empty, then one byte joins it
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 1, 1);
        chk("empty_flush", {31'b0, out_valid}, 32'h0);
        step(1, 8'h96, 1, 1);
        chk("flush96_word", out_word, 32'h96000000);
        chk("flush96_cnt", {29'b0, out_cnt}, 32'd1);
        step(0, 8'h00, 0, 1);

        // Flush coinciding with the 4th byte yields one full word only
        step(1, 8'h11, 0, 1);
        step(1, 8'h22, 0, 1);
        step(1, 8'h33, 0, 1);
        step(1, 8'hEE, 1, 1);
        chk("fl4_word", out_word, 32'h112233EE);
        chk("fl4_cnt", {29'b0, out_cnt}, 32'd4);
        step(0, 8'h00, 1, 1);
        chk("fl4_no_extra", {31'b0, out_valid}, 32'h0);

        // Reset mid-word with a stalled output
        step(1, 8'hAA, 0, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'h55, 0, 0);
        step(1, 8'h66, 0, 0);
        reset = 1'b0;
        step(0, 8'h00, 0, 0);
        chk("mrst_valid", {31'b0, out_valid}, 32'h0);
        chk("mrst_word", out_word, 32'h0);
        chk("mrst_cnt", {29'b0, out_cnt}, 32'h0);
        reset = 1'b1;
        step(1, 8'h9A, 0, 1);
        step(1, 8'hBC, 0, 1);
        step(0, 8'h00, 1, 1);
        chk("mrst_new_word", out_word, 32'h9ABC0000);
        chk("mrst_new_cnt", {29'b0, out_cnt}, 32'd2);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        end
        reset = 1'b1;
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_joiner.md
BYTE_JOINER -- requirements
Module: byte_joiner

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 SHALL provide port clk  input  1  rising-edge clock.
REQ-003 SHALL provide port reset  input  1  synchronous active-low reset; 0 sampled at a clk edge resets the block.
REQ-004 SHALL provide port in_valid  input  1  in_byte holds a valid byte this cycle.
REQ-005 SHALL provide port in_byte  input  8  byte to pack.
REQ-006 SHALL provide port in_ready  output  1  block accepts in_byte this cycle.
REQ-007 SHALL provide port in_flush  input  1  level request to emit a partial word.
REQ-008 SHALL provide port out_valid  output  1  out_word/out_cnt valid.
REQ-009 SHALL provide port out_ready  input  1  consumer takes the word this cycle.
REQ-010 SHALL provide port out_word  output  32  packed word; first byte received in [31:24].
REQ-011 SHALL provide port out_cnt  output  3  number of valid bytes in out_word (1..4).

Function
REQ-012 SHALL accept a byte when in_valid && in_ready at a clk edge ("accept").
REQ-013 SHALL hold an accumulator acc[31:0] and a count cnt (0..3); byte k (k=0..3) of a word goes to acc[31-8k:24-8k].
REQ-014 SHALL define the output slot as free in a cycle when !out_valid || out_ready.
REQ-015 SHALL drive in_ready = 1 when cnt<3, and when cnt==3 only if the slot is free (combinational).
REQ-016 SHALL, on accept with cnt==3, load out_word with the 4 bytes, set out_cnt=4, set out_valid=1 on the next cycle, and clear acc and cnt to 0.
REQ-017 SHALL, on accept with cnt<3, store the byte and increment cnt; out_* unaffected.
REQ-018 SHALL hold out_word, out_cnt and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid on out_ready unless a new word is loaded in the same cycle; back-to-back words give out_valid=1 with no bubble.
REQ-020 SHALL honour in_flush in a cycle when the slot is free and the effective count is >0 (cnt plus 1 if a byte is accepted this cycle).
REQ-021 SHALL, when the effective count is 4 because a 4th byte is accepted in the same cycle as in_flush, emit that full word via REQ-016 and treat the flush as satisfied.
REQ-022 SHALL, on an honoured flush with effective count 1..3, emit the accepted bytes in the high positions with lower bytes zero, out_cnt = effective count, and clear acc and cnt.
REQ-023 SHALL ignore in_flush when the effective count is 0 or the slot is not free; the requester holds in_flush until honoured.
REQ-024 SHALL keep acc and cnt unchanged when no byte is accepted and no flush is honoured.

Reset
REQ-025 SHALL, on reset==0 at a clk edge, set out_valid=0, out_word=32'h0, out_cnt=0, acc=0 and cnt=0; in_ready=1 from the following cycle.
REQ-026 SHALL discard any partial word and any pending output when reset occurs mid-word or while out_valid=1 and stalled.

Verification
REQ-027 SHALL cover: with out_ready=1, bytes AB,CD,12,34 on 4 consecutive cycles -> out_valid=1 on the next cycle with out_word=32'hABCD1234 and out_cnt=4.
REQ-028 SHALL cover: bytes 04,A5 then in_flush=1 -> out_word=32'h04A50000 and out_cnt=2; the next word starts at [31:24].
REQ-029 SHALL cover: out_ready=0 with word 32'h45140000... completed, then 3 further bytes -> in_ready drops when cnt==3; the first word stays stable; on out_ready=1 the 4th byte is accepted in the same cycle.
REQ-030 SHALL cover: in_flush held with cnt=0 -> no output; then one byte 96 is accepted -> out_word=32'h96000000 and out_cnt=1.
REQ-031 SHALL cover: in_flush in the same cycle as the 4th byte (EE) -> a single word with out_cnt=4 and no empty flush word afterwards.
REQ-032 SHALL cover: reset==0 after 2 bytes and with a stalled output -> all outputs 0; a fresh byte sequence packs from [31:24].
